// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl: multi-lane entry/exit sensing driving a saturating lot occupancy counter
module parking_occupancy_ctrl #(
    parameter int N_LANES    = 2,
    parameter int CAPACITY   = 100,
    parameter int CNT_W      = 7,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] sens_a,
    input  logic [N_LANES-1:0] sens_b,
    input  logic               cnt_load,
    input  logic [CNT_W-1:0]   cnt_load_val,
    input  logic               fault_clr,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic [N_LANES-1:0] lane_inc,
    output logic [N_LANES-1:0] lane_dec,
    output logic [N_LANES-1:0] lane_fault,
    output logic               overflow_err,
    output logic               underflow_err
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = CNT_W + $clog2(N_LANES + 1) + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
    localparam logic [CNT_W-1:0] CAP_U = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, FAULT} state_t;

    logic [2*N_LANES-1:0] raw, sync1, sync2, filt;
    logic [N_LANES-1:0]   entry, exit_ev, fault_set;
    logic signed [SW-1:0] n_inc, n_dec, sum;
    logic                 ovf, udf;
    logic [CNT_W-1:0]     load_val;

    assign raw = {sens_b, sens_a};

    // two-flop synchroniser for every raw sensor
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar j = 0; j < 2*N_LANES; j++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          f;
        // adopt a new level only once it has been seen for DEB_CYCLES consecutive samples
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt <= '0;
                f   <= 1'b0;
            end else if (sync2[j] == f) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                cnt <= '0;
                f   <= sync2[j];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
        assign filt[j] = f;
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        state_t        st, nxt;
        logic [TW-1:0] tmr;
        logic [1:0]    ab;
        logic          active, ent, ext, fset;
        assign ab     = {filt[i], filt[N_LANES+i]};
        assign active = st != IDLE && st != FAULT;
        // state register; dwell timer restarts on every transition and only runs mid-transit
        always_ff @(posedge clk) begin
            if (!reset) begin
                st  <= IDLE;
                tmr <= '0;
            end else begin
                st  <= nxt;
                tmr <= (nxt != st || !active) ? '0 : tmr + TW'(1);
            end
        end
        // sequence decoding; a transit stuck in one state too long is forced to FAULT
        always_comb begin
            nxt = st;
            case (st)
                IDLE:    nxt = ab == 2'b10 ? IN1  : ab == 2'b01 ? OUT1 : ab == 2'b11 ? FAULT : IDLE;
                IN1:     nxt = ab == 2'b11 ? IN2  : ab == 2'b00 ? IDLE : ab == 2'b01 ? FAULT : IN1;
                IN2:     nxt = ab == 2'b01 ? IN3  : ab == 2'b10 ? IN1  : ab == 2'b00 ? FAULT : IN2;
                IN3:     nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? IN2  : ab == 2'b10 ? FAULT : IN3;
                OUT1:    nxt = ab == 2'b11 ? OUT2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? FAULT : OUT1;
                OUT2:    nxt = ab == 2'b10 ? OUT3 : ab == 2'b01 ? OUT1 : ab == 2'b00 ? FAULT : OUT2;
                OUT3:    nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? OUT2 : ab == 2'b01 ? FAULT : OUT3;
                FAULT:   nxt = ab == 2'b00 ? IDLE : FAULT;
                default: nxt = IDLE;
            endcase
            if (active && nxt == st && tmr == TW'(TIMEOUT - 1)) nxt = FAULT;
        end
        // completed transits and fault entry for this lane
        always_comb begin
            ent  = st == IN3 && nxt == IDLE;
            ext  = st == OUT3 && nxt == IDLE;
            fset = nxt == FAULT && st != FAULT;
        end
        assign entry[i]     = ent;
        assign exit_ev[i]   = ext;
        assign fault_set[i] = fset;
    end

    // net occupancy change from this cycle's completed transits, checked against both limits
    always_comb begin
        n_inc = '0;
        n_dec = '0;
        for (int k = 0; k < N_LANES; k++) begin
            n_inc = n_inc + SW'(entry[k]);
            n_dec = n_dec + SW'(exit_ev[k]);
        end
        sum      = $signed(SW'(occupancy)) + n_inc - n_dec;
        ovf      = sum > CAP_S;
        udf      = sum < 0;
        load_val = cnt_load_val > CAP_U ? CAP_U : cnt_load_val;
    end

    // occupancy, lane pulses and sticky flags all update on the same edge; a new set beats a clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            occupancy     <= '0;
            lane_inc      <= '0;
            lane_dec      <= '0;
            lane_fault    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            lane_inc      <= entry;
            lane_dec      <= exit_ev;
            lane_fault    <= fault_set | (lane_fault & {N_LANES{~fault_clr}});
            occupancy     <= cnt_load ? load_val : ovf ? CAP_U : udf ? '0 : sum[CNT_W-1:0];
            overflow_err  <= (!cnt_load && ovf) || (overflow_err && !fault_clr);
            underflow_err <= (!cnt_load && udf) || (underflow_err && !fault_clr);
        end
    end

    assign full  = occupancy == CAP_U;
    assign empty = occupancy == '0;
endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb_parking_occupancy_ctrl: scoreboard bench with transit-level reference model
module tb_parking_occupancy_ctrl;
    localparam int CAP = 3;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    sens_a = '0, sens_b = '0;
    logic          cnt_load = 1'b0;
    logic [CW-1:0] cnt_load_val = '0;
    logic          fault_clr = 1'b0;
    logic [CW-1:0] occupancy;
    logic          full, empty, overflow_err, underflow_err;
    logic [1:0]    lane_inc, lane_dec, lane_fault;

    parking_occupancy_ctrl #(
        .N_LANES(2), .CAPACITY(CAP), .CNT_W(CW), .DEB_CYCLES(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .fault_clr(fault_clr),
        .occupancy(occupancy), .full(full), .empty(empty),
        .lane_inc(lane_inc), .lane_dec(lane_dec), .lane_fault(lane_fault),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] inc;
        logic [1:0] dec;
        logic [2:0] occ;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         m_occ = 0;
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic [1:0] m_fault = '0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Scenario n: 4 ab levels per lane. 0 idle, 1 entry, 2 exit, 3 entry aborted,
    // 4 illegal jump, 5 both beams from idle, 6 exit aborted.
    function automatic logic [1:0] step_ab(input int sc, input int k);
        logic [7:0] p;
        case (sc)
            1:       p = 8'b10_11_01_00;
            2:       p = 8'b01_11_10_00;
            3:       p = 8'b10_11_10_00;
            4:       p = 8'b10_01_01_00;
            5:       p = 8'b11_11_00_00;
            6:       p = 8'b01_11_01_00;
            default: p = 8'b00_00_00_00;
        endcase
        return p[7-2*k -: 2];
    endfunction

    function automatic logic sc_fault(input int sc);
        return sc == 4 || sc == 5;
    endfunction

    // lot model: a load replaces the count; otherwise apply net car change with clamping
    task automatic model_events(input logic [1:0] inc, input logic [1:0] dec, input logic load, input int lval);
        int   nx;
        exp_t e;
        if (load) begin
            m_occ = lval > CAP ? CAP : lval;
        end else begin
            nx = m_occ + $countones(inc) - $countones(dec);
            if (nx > CAP) begin
                m_occ = CAP;
                m_ovf = 1'b1;
            end else if (nx < 0) begin
                m_occ = 0;
                m_udf = 1'b1;
            end else begin
                m_occ = nx;
            end
        end
        if ((inc | dec) != 2'b00) begin
            e.inc   = inc;
            e.dec   = dec;
            e.occ   = 3'(m_occ);
            e.full  = m_occ == CAP;
            e.empty = m_occ == 0;
            e.ovf   = m_ovf;
            e.udf   = m_udf;
            sbq.push_back(e);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_occupancy"}, int'(occupancy), m_occ);
        chk({tag, "_full"}, int'(full), int'(m_occ == CAP));
        chk({tag, "_empty"}, int'(empty), int'(m_occ == 0));
        chk({tag, "_overflow"}, int'(overflow_err), int'(m_ovf));
        chk({tag, "_underflow"}, int'(underflow_err), int'(m_udf));
        chk({tag, "_lane_fault"}, int'(lane_fault), int'(m_fault));
        chk({tag, "_pending_pulses"}, sbq.size(), 0);
    endtask

    task automatic clear_flags();
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_fault = '0;
    endtask

    task automatic set_lane(input int l, input logic [1:0] ab);
        sens_a[l] = ab[1];
        sens_b[l] = ab[0];
    endtask

    task automatic run_round(input int sc0, input int sc1, input int h, input logic load, input int lval);
        logic [1:0] inc, dec;
        inc = {sc1 == 1, sc0 == 1};
        dec = {sc1 == 2, sc0 == 2};
        if (load) begin
            model_events(2'b00, 2'b00, 1'b1, lval);
            cnt_load     = 1'b1;
            cnt_load_val = CW'(lval);
            @(posedge clk); #1;
            cnt_load = 1'b0;
        end
        model_events(inc, dec, 1'b0, 0);
        m_fault = m_fault | {sc_fault(sc1), sc_fault(sc0)};
        for (int k = 0; k < 4; k++) begin
            set_lane(0, step_ab(sc0, k));
            set_lane(1, step_ab(sc1, k));
            repeat (h) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        check_status("round");
    endtask

    // monitor: every lane pulse must match the next expected transit completion
    always @(negedge clk) begin
        exp_t e;
        if (reset && (lane_inc != 2'b00 || lane_dec != 2'b00)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: inc=%b dec=%b, no pulse expected (t=%0t)", lane_inc, lane_dec, $time);
            end else begin
                e = sbq.pop_front();
                chk("pulse_inc", int'(lane_inc), int'(e.inc));
                chk("pulse_dec", int'(lane_dec), int'(e.dec));
                chk("pulse_occupancy", int'(occupancy), int'(e.occ));
                chk("pulse_full", int'(full), int'(e.full));
                chk("pulse_empty", int'(empty), int'(e.empty));
                chk("pulse_overflow", int'(overflow_err), int'(e.ovf));
                chk("pulse_underflow", int'(underflow_err), int'(e.udf));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        chk("reset_lane_inc", int'(lane_inc), 0);
        chk("reset_lane_dec", int'(lane_dec), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single entry from an empty lot
        run_round(1, 0, 8, 1'b0, 0);

        // three-cycle glitch on lane0 a must be filtered out
        sens_a[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sens_a[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_status("glitch");

        // two simultaneous entries at occupancy 2 overflow
        run_round(1, 1, 8, 1'b1, 2);
        clear_flags();
        check_status("clear_after_overflow");

        // exit and entry completing together net to zero
        run_round(2, 1, 8, 1'b1, 1);

        // lane1 stuck with both beams broken times out
        set_lane(1, 2'b10);
        repeat (8) @(posedge clk);
        #1;
        set_lane(1, 2'b11);
        repeat (20) @(posedge clk);
        #1;
        set_lane(1, 2'b00);
        repeat (12) @(posedge clk);
        #1;
        m_fault[1] = 1'b1;
        check_status("timeout");
        run_round(0, 1, 8, 1'b0, 0);
        clear_flags();
        check_status("fault_clear");

        // preload collides with a lane0 entry completion
        for (int k = 0; k < 3; k++) begin
            set_lane(0, step_ab(1, k));
            repeat (8) @(posedge clk);
            #1;
        end
        model_events(2'b01, 2'b00, 1'b1, 7);
        set_lane(0, 2'b00);
        repeat (6) @(posedge clk);
        #1;
        cnt_load     = 1'b1;
        cnt_load_val = 3'd7;
        @(posedge clk); #1;
        cnt_load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_status("load_collide");

        // reset in the middle of a transit discards it
        set_lane(0, 2'b10);
        repeat (8) @(posedge clk);
        #1;
        set_lane(0, 2'b11);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        set_lane(0, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        m_occ   = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_fault = '0;
        check_status("reset_mid");
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_status("post_reset");

        // randomized traffic on both lanes
        for (int r = 0; r < 40; r++) begin
            run_round(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(6, 10)),
                      $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                clear_flags();
                check_status("random_clear");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
